// File: rtl/pwm.sv
// Single-channel edge-aligned PWM: prescaled tick drives a wrapping period counter,
// and the registered output is high while the counter is below a period-latched compare.
module pwm #(
  parameter int KPERIOD = 1000,
  parameter int KCLKDIV = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(KPERIOD)-1:0] CMPA,
  output logic                       PWM_OUT
);

  localparam int PW = $clog2(KPERIOD);
  localparam logic [PW-1:0] PER_LAST = PW'(KPERIOD - 1);

  logic          tick;
  logic          wrap;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic [PW-1:0] cmp_sh_q, cmp_sh_d;
  logic          load_pend_q, load_pend_d;
  logic          pwm_q, pwm_d;

  generate
    if (KCLKDIV == 1) begin : g_nodiv
      assign tick = 1'b1;
    end else begin : g_div
      localparam int DW = $clog2(KCLKDIV);
      localparam logic [DW-1:0] DIV_LAST = DW'(KCLKDIV - 1);
      logic [DW-1:0] div_cnt_q, div_cnt_d;

      assign tick      = (div_cnt_q == DIV_LAST);
      assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          div_cnt_q <= '0;
        end else begin
          div_cnt_q <= div_cnt_d;
        end
      end
    end
  endgenerate

  // The shadow only changes at a period boundary so the active compare never glitches mid-period.
  always_comb begin
    wrap        = tick && (per_cnt_q == PER_LAST);
    per_cnt_d   = per_cnt_q;
    cmp_sh_d    = cmp_sh_q;
    load_pend_d = 1'b0;
    if (tick) begin
      per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
    end
    if (load_pend_q || wrap) begin
      cmp_sh_d = CMPA;
    end
    pwm_d = (per_cnt_q < cmp_sh_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_cnt_q   <= '0;
      cmp_sh_q    <= '0;
      load_pend_q <= 1'b1;
      pwm_q       <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      cmp_sh_q    <= cmp_sh_d;
      load_pend_q <= load_pend_d;
      pwm_q       <= pwm_d;
    end
  end

  assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: an arithmetic model (edges since release -> tick count ->
// period position) checked every cycle, plus literal high-time and edge expectations.
module tb_pwm;
  localparam int KP = 1000;
  localparam int KD = 10;
  localparam int SP = 4;
  localparam int SD = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rst_s = 1'b0;
  logic [9:0] cmpa = '0;
  logic [1:0] cmpa_s = '0;
  logic       pwm_out;
  logic       pwm_out_s;

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;
  bit  chk_en_s = 1'b0;

  always #5 clk = ~clk;

  pwm #(.KPERIOD(KP), .KCLKDIV(KD)) u_main (
    .clk(clk), .rst(rst), .CMPA(cmpa), .PWM_OUT(pwm_out)
  );

  pwm #(.KPERIOD(SP), .KCLKDIV(SD)) u_small (
    .clk(clk), .rst(rst_s), .CMPA(cmpa_s), .PWM_OUT(pwm_out_s)
  );

  // Model: after e edges since release, ticks = e/KCLKDIV, position = ticks mod KPERIOD.
  // Output at edge e+1 compares position after e edges with the shadow held then.
  // Shadow loads on edge 1 and on every edge that is a multiple of KPERIOD*KCLKDIV.
  int m_e, m_cmp;
  bit m_out;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_e <= 0; m_cmp <= 0; m_out <= 1'b0;
    end else begin
      m_out <= (((m_e / KD) % KP) < m_cmp);
      m_e   <= m_e + 1;
      if (m_e == 0 || ((m_e + 1) % (KD * KP)) == 0) m_cmp <= int'(cmpa);
    end
  end

  int s_e, s_cmp;
  bit s_out;
  always @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      s_e <= 0; s_cmp <= 0; s_out <= 1'b0;
    end else begin
      s_out <= (((s_e / SD) % SP) < s_cmp);
      s_e   <= s_e + 1;
      if (s_e == 0 || ((s_e + 1) % (SD * SP)) == 0) s_cmp <= int'(cmpa_s);
    end
  end

  task automatic check_bit(string name, logic act, logic exp, bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end else if (verbose) begin
      $display("ok   %s: got %b at %0t", name, act, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: got %0d at %0t", name, act, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en)   check_bit("main_model", pwm_out, m_out, 1'b0);
    if (chk_en_s) check_bit("small_model", pwm_out_s, s_out, 1'b0);
  end

  task automatic do_reset(input logic [9:0] c);
    @(negedge clk);
    rst  = 1'b0;
    cmpa = c;
    @(negedge clk);
    check_bit("reset_out_low", pwm_out, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic count_high(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (pwm_out === 1'b1) cnt++;
    end
  endtask

  // Reset with compare c, skip edge 1, count highs over edges 2..n+1.
  task automatic window(input logic [9:0] c, input int n, input int exp, input string name);
    int cnt;
    do_reset(c);
    @(negedge clk);
    check_bit({name, "_edge1_low"}, pwm_out, 1'b0, 1'b1);
    count_high(n, cnt);
    check_int(name, cnt, exp);
  endtask

  initial begin
    int cnt;
    logic [3:0] pat;
    logic [3:0] exp_pat;

    // KPERIOD=4, KCLKDIV=1, CMPA=2: steady pattern 1,1,0,0 from edge 5
    @(negedge clk);
    rst_s  = 1'b0;
    cmpa_s = 2'd2;
    @(negedge clk);
    @(negedge clk);
    rst_s    = 1'b1;
    chk_en_s = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[3 - i] = pwm_out_s;
    end
    exp_pat = 4'b1100;
    check_int("small_pattern_edges5to8", int'(pat), int'(exp_pat));
    repeat (12) @(negedge clk);

    // Full-period high times measured over one whole period
    window(10'd200, KP * KD, 2000, "high_cmpa200");
    window(10'd999, KP * KD, 9990, "high_cmpa999");
    window(10'd1,   KP * KD, 10,   "high_cmpa1");
    window(10'd0,    2000, 0,    "const_low_cmpa0");
    window(10'd1000, 2000, 2000, "const_high_cmpa1000");
    window(10'd1023, 2000, 2000, "const_high_cmpa1023");

    // Mid-period change at per_cnt=350 is ignored until the wrap
    do_reset(10'd200);
    repeat (3501) @(negedge clk);
    cmpa = 10'd500;
    count_high(6499, cnt);
    check_int("midperiod_change_ignored", cnt, 0);
    count_high(KP * KD, cnt);
    check_int("next_period_cmpa500", cnt, 5000);

    // Asynchronous reset while high at per_cnt=100
    do_reset(10'd200);
    repeat (1001) @(negedge clk);
    check_bit("high_before_async_rst", pwm_out, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 check_bit("async_rst_drop", pwm_out, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_bit("post_rst_edge1_low", pwm_out, 1'b0, 1'b1);
    @(negedge clk);
    check_bit("post_rst_edge2_high", pwm_out, 1'b1, 1'b1);
    repeat (200) @(negedge clk);

    chk_en   = 1'b0;
    chk_en_s = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
